two_port_mem_arbiter: RTL
=========================

TWO_PORT_MEM_ARBITER -- requirements
Module: two_port_mem_arbiter

Interface
REQ-001 Parameter addresses, default 32: memory depth.
REQ-002 Parameter width, default 8: data bits per word.
REQ-003 Parameter requesters, default 4: requester count; shall be 2 or more. Derived localparam addressWidth = $clog2(addresses).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Port list (name, direction, width, meaning):
- clk  in  1  clock for the arbiter and both memory ports.
- reset  in  1  asynchronous, active-high.
- writeReq  in  requesters  per-requester write request.
- writeAddressIn  in  requesters*addressWidth  packed write addresses; requester i at slice i.
- writeDataIn  in  requesters*width  packed write data.
- writeGrant  out  requesters  one-hot write grant.
- readReq  in  requesters  per-requester read request.
- readAddressIn  in  requesters*addressWidth  packed read addresses.
- readGrant  out  requesters  one-hot read grant.
- readDataOut  out  width  returned read data.
- readDataValid  out  requesters  one-hot; marks the owner of readDataOut.
- busy  out  1  initialisation in progress.
- memWriteAddress  out  addressWidth, to the memory.
- memWriteEnable  out  1, to the memory.
- memWriteData  out  width, to the memory.
- memReadAddress  out  addressWidth, to the memory.
- memReadEnable  out  1, to the memory.
- memReadData  in  width, from the memory; registered, 1-cycle latency.

Function
REQ-006 Write and read ports SHALL be arbitrated independently, each by its own round-robin arbiter.
REQ-007 Grant SHALL be combinational in the cycle a request is seen, while state is RUN; at most one grant per port per cycle.
REQ-008 A requester SHALL hold its request, address and data stable until granted. The grant completes the transaction. Keeping the request asserted the next cycle issues a new request.
REQ-009 The granted write SHALL drive memWriteEnable=1 plus the granted address and data; the write commits at that clk edge.
REQ-010 The granted read SHALL drive memReadEnable=1 and the granted address. On the next cycle, readDataOut=memReadData and readDataValid equals the previous cycle's readGrant.
REQ-011 Round-robin: after reset requester 0 has highest priority. After a grant to requester k, priority starts at k+1 and wraps from requesters-1 to 0. The pointer SHALL NOT move when there is no grant.
REQ-012 A read and a write to the same address in the same cycle SHALL return the old data; there is no bypass.
REQ-013 No requests: memWriteEnable=0, memReadEnable=0, all grants 0.
REQ-014 FSM states INIT and RUN. INIT->RUN after the last init write. RUN is held until reset.

Reset
REQ-015 Asserting reset SHALL immediately force:
- writeGrant=0, readGrant=0, readDataValid=0, readDataOut=0;
- memWriteEnable=0, memReadEnable=0;
- both round-robin pointers to 0;
- the init counter to 0.
REQ-016 Reset asserted mid-INIT SHALL restart initialisation from address 0.
REQ-017 Reset asserted with a read in flight SHALL suppress that read's readDataValid.

Configuration
REQ-018 Macro TWO_PORT_MEM_ARBITER_INIT_EN defined:
- reset enters INIT with busy=1;
- one cycle per address, write 0 to addresses 0..addresses-1 ascending;
- no grants during INIT.
REQ-019 Macro undefined: reset enters RUN directly, busy is tied 0, and no init counter is built.

Structure
REQ-020 Package two_port_mem_arbiter_pkg SHALL hold the FSM state typedef (INIT, RUN).
REQ-021 Sub-module rr_arbiter (parameter requesters; inputs req, advance; output one-hot grant) SHALL be instantiated twice, once for write and once for read.

Verification
REQ-022 With INIT_EN:
- reset released -> busy=1 for 32 cycles;
- memWriteAddress steps 0..31 with data 0;
- then a read of address 9 returns 0x00.
REQ-023 writeReq[0] with address 5 and data 0xA5 is granted. Then readReq[1] address 5 -> readDataValid=4'b0010 one cycle after readGrant, readDataOut=0xA5.
REQ-024 All four writeReq held for 5 cycles -> writeGrant sequence 0001, 0010, 0100, 1000, 0001.
REQ-025 Address 7 holds 0x11; a write of 0x22 and a read of address 7 in the same cycle -> read returns 0x11. The next read returns 0x22.
REQ-026 Reset pulsed when INIT has reached address 10 -> init restarts at address 0, and busy stays high for a further 32 cycles.
REQ-027 Requester 2 asserts writeReq and readReq to different addresses in the same cycle -> both writeGrant[2] and readGrant[2] assert in that cycle.

Source files
------------

// File: rtl/two_port_mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: the controller FSM state.
package two_port_mem_arbiter_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/two_port_mem_arbiter_if.sv
// Requester and memory bus of the two-port arbiter; slave = arbiter side,
// master = requesters plus the synchronous memory.
interface two_port_mem_arbiter_if #(
    parameter int addresses  = 32,
    parameter int width      = 8,
    parameter int requesters = 4
);
    localparam int addressWidth = $clog2(addresses);

    logic [requesters-1:0]              writeReq;
    logic [requesters*addressWidth-1:0] writeAddressIn;
    logic [requesters*width-1:0]        writeDataIn;
    logic [requesters-1:0]              writeGrant;
    logic [requesters-1:0]              readReq;
    logic [requesters*addressWidth-1:0] readAddressIn;
    logic [requesters-1:0]              readGrant;
    logic [width-1:0]                   readDataOut;
    logic [requesters-1:0]              readDataValid;
    logic                               busy;
    logic [addressWidth-1:0]            memWriteAddress;
    logic                               memWriteEnable;
    logic [width-1:0]                   memWriteData;
    logic [addressWidth-1:0]            memReadAddress;
    logic                               memReadEnable;
    logic [width-1:0]                   memReadData;

    modport slave (
        input  writeReq, writeAddressIn, writeDataIn, readReq, readAddressIn,
               memReadData,
        output writeGrant, readGrant, readDataOut, readDataValid, busy,
               memWriteAddress, memWriteEnable, memWriteData,
               memReadAddress, memReadEnable
    );

    modport master (
        output writeReq, writeAddressIn, writeDataIn, readReq, readAddressIn,
               memReadData,
        input  writeGrant, readGrant, readDataOut, readDataValid, busy,
               memWriteAddress, memWriteEnable, memWriteData,
               memReadAddress, memReadEnable
    );

endinterface

// File: rtl/two_port_mem_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, priority pointer moves
// past the winner only on cycles where advance is set and something wins.
module rr_arbiter #(
    parameter int requesters = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [requesters-1:0] req,
    input  logic                  advance,
    output logic [requesters-1:0] grant
);
    localparam int idxWidth = $clog2(requesters);

    logic [idxWidth-1:0] r_ptr;
    logic [idxWidth-1:0] w_idx;
    logic                w_found;

    // Scan requesters starting at the pointer, wrapping past the last one.
    always_comb begin
        grant   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 0; i < requesters; i++) begin
            for (int j = 0; j < requesters; j++) begin
                if (!w_found && req[j] && (j == (int'(r_ptr) + i) % requesters)) begin
                    grant[j] = 1'b1;
                    w_idx    = idxWidth'(j);
                    w_found  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (advance && w_found) begin
            r_ptr <= (w_idx == idxWidth'(requesters - 1)) ? '0 : w_idx + idxWidth'(1);
        end
    end

endmodule

// File: rtl/two_port_mem_arbiter.sv
// Two-port memory arbiter: independent round-robin write and read ports.
// Define TWO_PORT_MEM_ARBITER_INIT_EN to zero-fill the memory after reset.
module two_port_mem_arbiter
    import two_port_mem_arbiter_pkg::*;
#(
    parameter int addresses  = 32,
    parameter int width      = 8,
    parameter int requesters = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    two_port_mem_arbiter_if.slave        bus
);
    localparam int addressWidth = $clog2(addresses);

    arb_state_t              r_state;
    arb_state_t              w_stateNext;
    logic                    w_run;
    logic                    w_lastInit;
    logic                    w_initWrite;
    logic [requesters-1:0]   w_wrReqGated;
    logic [requesters-1:0]   w_rdReqGated;
    logic [requesters-1:0]   w_wrGrant;
    logic [requesters-1:0]   w_rdGrant;
    logic [requesters-1:0]   r_rdValid;
    logic [addressWidth-1:0] w_wrAddr;
    logic [addressWidth-1:0] w_rdAddr;
    logic [width-1:0]        w_wrData;

`ifdef TWO_PORT_MEM_ARBITER_INIT_EN
    localparam arb_state_t ResetState = INIT;

    logic [addressWidth-1:0] r_initAddr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_initAddr <= '0;
        end else if (r_state == INIT) begin
            r_initAddr <= r_initAddr + addressWidth'(1);
        end
    end

    assign w_lastInit          = (r_initAddr == addressWidth'(addresses - 1));
    assign w_initWrite         = (r_state == INIT) && !reset;
    assign bus.busy            = (r_state == INIT);
    assign bus.memWriteAddress = w_initWrite ? r_initAddr : w_wrAddr;
`else
    localparam arb_state_t ResetState = RUN;

    assign w_lastInit          = 1'b1;
    assign w_initWrite         = 1'b0;
    assign bus.busy            = 1'b0;
    assign bus.memWriteAddress = w_wrAddr;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ResetState;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            INIT:    if (w_lastInit) w_stateNext = RUN;
            RUN:     w_stateNext = RUN;
            default: w_stateNext = ResetState;
        endcase
    end

    // Reset gates grants combinationally so they drop the moment it asserts.
    assign w_run        = (r_state == RUN) && !reset;
    assign w_wrReqGated = bus.writeReq & {requesters{w_run}};
    assign w_rdReqGated = bus.readReq  & {requesters{w_run}};

    rr_arbiter #(.requesters(requesters)) u_wr_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (w_wrReqGated),
        .advance (w_run),
        .grant   (w_wrGrant)
    );

    rr_arbiter #(.requesters(requesters)) u_rd_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (w_rdReqGated),
        .advance (w_run),
        .grant   (w_rdGrant)
    );

    always_comb begin
        w_wrAddr = '0;
        w_wrData = '0;
        w_rdAddr = '0;
        for (int i = 0; i < requesters; i++) begin
            if (w_wrGrant[i]) begin
                w_wrAddr = bus.writeAddressIn[i*addressWidth +: addressWidth];
                w_wrData = bus.writeDataIn[i*width +: width];
            end
            if (w_rdGrant[i]) begin
                w_rdAddr = bus.readAddressIn[i*addressWidth +: addressWidth];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdValid <= '0;
        end else begin
            r_rdValid <= w_rdGrant;
        end
    end

    assign bus.writeGrant     = w_wrGrant;
    assign bus.readGrant      = w_rdGrant;
    assign bus.memWriteEnable = w_initWrite | (|w_wrGrant);
    assign bus.memWriteData   = w_wrData;
    assign bus.memReadEnable  = |w_rdGrant;
    assign bus.memReadAddress = w_rdAddr;
    assign bus.readDataValid  = r_rdValid;
    // The memory's registered output is only exposed while its read owner is flagged.
    assign bus.readDataOut    = (|r_rdValid) ? bus.memReadData : '0;

endmodule
